// File: rtl/ibex_imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// Holds the LFSR constants, the response entry type and the address check.
package ibex_imem_pkg;

  localparam logic [15:0] IMEM_RESP_LFSR_SEED = 16'hACE1;
  // Right-shift Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] IMEM_RESP_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } imem_resp_t;

  // 1 when the byte address falls outside the window or is not word aligned
  function automatic logic imem_addr_err(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(words) << 2);
    return (addr < base) | ({1'b0, addr} >= limit) | (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ibex_imem_resp_fifo.sv
// In-order response FIFO with circular pointers; depth need not be a power of two.
module ibex_imem_resp_fifo
  import ibex_imem_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  imem_resp_t data_i,
  input  logic       pop_i,
  output imem_resp_t data_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  imem_resp_t            mem_q [Depth];
  logic [PtrW-1:0]       wr_q, rd_q;
  logic [CntW-1:0]       cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (pop_i)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Payload needs no reset: empty_o masks stale entries
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));

endmodule

// File: rtl/ibex_imem_responder.sv
// Instruction-fetch bus responder in front of a 1-cycle synchronous SRAM.
// Define IBEX_IMEM_RESP_RANDOM_STALL_EN to add LFSR-driven random grant stalls.
module ibex_imem_responder
  import ibex_imem_pkg::*;
#(
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned WaitStates     = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  output logic                        mem_req_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  input  logic [31:0]                 mem_rdata_i
);

  localparam int unsigned AW   = $clog2(MemWords);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic            err_req, stall, gnt, rvalid;
  logic [AW-1:0]   word_idx;
  logic [CntW-1:0] out_cnt_q;
  logic [2:0]      ws_cnt_q;
  logic            s1_vld_q, s1_err_q;
  imem_resp_t      push_data, head;
  logic            fifo_empty, fifo_full;

  assign err_req  = imem_addr_err(instr_addr_i, BaseAddr, MemWords);
  assign word_idx = AW'((instr_addr_i - BaseAddr) >> 2);

`ifdef IBEX_IMEM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= IMEM_RESP_LFSR_SEED;
    else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? IMEM_RESP_LFSR_TAPS : 16'h0);
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Grant is gated by rst_i so every output reads 0 while reset is held
  assign gnt         = ~rst_i & instr_req_i & (out_cnt_q < CntW'(MaxOutstanding)) & ~stall;
  assign instr_gnt_o = gnt;
  assign mem_req_o   = gnt & ~err_req;
  assign mem_addr_o  = mem_req_o ? word_idx : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s1_err_q <= 1'b0;
    end else begin
      s1_vld_q <= gnt;
      s1_err_q <= err_req;
    end
  end

  assign push_data.err  = s1_err_q;
  assign push_data.data = s1_err_q ? 32'h0 : mem_rdata_i;

  ibex_imem_resp_fifo #(
    .Depth (MaxOutstanding)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (s1_vld_q),
    .data_i  (push_data),
    .pop_i   (rvalid),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Outstanding limit keeps S1 plus FIFO contents within the FIFO depth
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(s1_vld_q && fifo_full && !rvalid));
  end

  // Reload while there is no head (or it leaves) so the next head starts at WaitStates
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    ws_cnt_q <= 3'(WaitStates);
    else if (fifo_empty | rvalid) ws_cnt_q <= 3'(WaitStates);
    else if (ws_cnt_q != 3'd0)    ws_cnt_q <= ws_cnt_q - 3'd1;
  end

  assign rvalid         = ~fifo_empty & (ws_cnt_q == 3'd0);
  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? head.data : 32'h0;
  assign instr_err_o    = rvalid & head.err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q <= '0;
    end else begin
      unique case ({gnt, rvalid})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_imem_responder.sv
// Randomised bench: two responders (no wait states / three wait states) share
// the request stream and are checked against a timing-queue reference model.
module tb_ibex_imem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;
  localparam int          AW    = 6;
  localparam int          MAXO0 = 2, WS0 = 0;
  localparam int          MAXO1 = 2, WS1 = 3;

  typedef struct packed {
    int          rdy;
    logic        err;
    logic [31:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, req;
  logic [31:0]   addr;
  logic          gnt [2], rv [2], err [2], mreq [2];
  logic [31:0]   rdata [2], mrdata [2];
  logic [AW-1:0] maddr [2];

  logic [31:0]   mem [WORDS];
  ent_t          mq [2][8];
  int            hd [2], cnt [2], last_r [2];
  bit            rd_pend [2];
  logic [AW-1:0] rd_idx [2];
  logic [15:0]   lfsr;
  int            cyc = 0;
  int            n_chk = 0, n_err = 0;
  int            stall_cyc = 0, cap_cyc = 0;

  always #5 clk = ~clk;

  ibex_imem_responder #(
    .BaseAddr(BASE), .MemWords(WORDS), .MaxOutstanding(MAXO0), .WaitStates(WS0)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rdata[0]),
    .instr_err_o(err[0]), .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]),
    .mem_rdata_i(mrdata[0])
  );

  ibex_imem_responder #(
    .BaseAddr(BASE), .MemWords(WORDS), .MaxOutstanding(MAXO1), .WaitStates(WS1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rdata[1]),
    .instr_err_o(err[1]), .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]),
    .mem_rdata_i(mrdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int maxo(input int k);
    return (k == 0) ? MAXO0 : MAXO1;
  endfunction

  function automatic int wst(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    longint a64;
    a64 = longint'(a);
    return (a64 < longint'(BASE)) || (a64 >= longint'(BASE) + 4 * WORDS) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] off;
    off = 32'($urandom_range(0, WORDS - 1)) << 2;
    case ($urandom_range(0, 9))
      0:       return BASE - 32'($urandom_range(1, 16));
      1:       return BASE + 4 * WORDS + 32'($urandom_range(0, 12));
      2:       return BASE + off + 32'($urandom_range(1, 3));
      3:       return 32'hFFFF_FFFC;
      default: return BASE + off;
    endcase
  endfunction

  // One bus cycle: drive, check at negedge against the model, advance at posedge
  task automatic step(input bit r, input bit rq, input logic [31:0] a);
    bit stall, eg, ebad, ev;
    logic [AW-1:0] idx;
    ent_t e;
    int rdy;
    rst = r; req = rq; addr = a;
    @(negedge clk);
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k] = 0; hd[k] = 0; last_r[k] = -100;
      end
      lfsr = 16'hACE1;
    end
`ifdef IBEX_IMEM_RESP_RANDOM_STALL_EN
    stall = (lfsr[1:0] == 2'b00);
`else
    stall = 1'b0;
`endif
    ebad = addr_bad(a);
    idx  = AW'((a - BASE) >> 2);
    for (int k = 0; k < 2; k++) begin
      eg = !r && rq && (cnt[k] < maxo(k)) && !stall;
      if (k == 0 && !r && rq && cnt[0] < maxo(0)) begin
        cap_cyc++;
        if (!gnt[0]) stall_cyc++;
      end
      chk($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(eg));
      chk($sformatf("mem_req%0d", k), 32'(mreq[k]), 32'(eg && !ebad));
      if (eg && !ebad) chk($sformatf("mem_addr%0d", k), 32'(maddr[k]), 32'(idx));
      if (r) chk($sformatf("rst_mem_addr%0d", k), 32'(maddr[k]), 32'h0);
      ev = !r && cnt[k] > 0 && mq[k][hd[k]].rdy == cyc;
      chk($sformatf("rvalid%0d", k), 32'(rv[k]), 32'(ev));
      chk($sformatf("rdata%0d", k), rdata[k], ev ? mq[k][hd[k]].data : 32'h0);
      chk($sformatf("err%0d", k), 32'(err[k]), ev ? 32'(mq[k][hd[k]].err) : 32'h0);
      if (ev) begin
        hd[k] = (hd[k] + 1) % 8;
        cnt[k]--;
      end
      if (eg) begin
        rdy = (cyc + 2 > last_r[k] + 1) ? cyc + 2 : last_r[k] + 1;
        rdy += wst(k);
        e.rdy  = rdy;
        e.err  = ebad;
        e.data = ebad ? 32'h0 : mem[idx];
        mq[k][(hd[k] + cnt[k]) % 8] = e;
        cnt[k]++;
        last_r[k] = rdy;
      end
      rd_pend[k] = mreq[k];
      rd_idx[k]  = maddr[k];
    end
    @(posedge clk);
    #1;
    if (!r) lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
    for (int k = 0; k < 2; k++)
      mrdata[k] = rd_pend[k] ? mem[rd_idx[k]] : $urandom;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0;
    mrdata[0] = '0; mrdata[1] = '0;
    lfsr = 16'hACE1;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[2] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    step(1, 0, '0);
    step(1, 1, BASE);

    // single fetch, then the error/ordering trio
    step(0, 1, BASE + 8);
    for (int i = 0; i < 6; i++) step(0, 0, $urandom);
    step(0, 1, BASE + 4 * WORDS);
    step(0, 1, BASE + 2);
    step(0, 1, BASE + 12);
    for (int i = 0; i < 14; i++) step(0, 0, $urandom);

    // request held for six cycles against the outstanding limit
    for (int i = 0; i < 6; i++) step(0, 1, BASE + 16);
    for (int i = 0; i < 12; i++) step(0, 0, '0);

    // continuous valid requests
    for (int i = 0; i < 40; i++) step(0, 1, BASE + (32'($urandom_range(0, WORDS - 1)) << 2));

    // random mix
    for (int i = 0; i < 400; i++) step(0, ($urandom_range(0, 9) < 7), rand_addr());

    // reset with transactions in flight
    step(0, 1, BASE + 4);
    step(0, 1, BASE + 8);
    step(1, 1, BASE + 12);
    for (int i = 0; i < 60; i++) step(0, ($urandom_range(0, 3) != 0), rand_addr());

`ifdef IBEX_IMEM_RESP_RANDOM_STALL_EN
    cap_cyc = 0; stall_cyc = 0;
    for (int i = 0; i < 1000; i++) step(0, 1, rand_addr());
    chk("stall_ratio_in_20_30pct", 32'((stall_cyc * 100 >= cap_cyc * 20) && (stall_cyc * 100 <= cap_cyc * 30)), 32'h1);
`endif

    for (int i = 0; i < 16; i++) step(0, 0, '0);
    chk("drained0", 32'(cnt[0]), 32'h0);
    chk("drained1", 32'(cnt[1]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
